sync_ram_dp: RTL
================

// Module: sync_ram_dp
// PURPOSE
//  Parametrised simple-dual-port synchronous RAM with per-byte write enables, optional output
//  register, selectable mixed-port read-during-write, and a post-reset clear sequencer.
//  Replaces fixed 32-bit/4-byte RAM models in caches and register files; port A read/write,
//  port B read-only. Synthesisable; no vendor primitive required.
// PARAMETERS
//  WIDTH       32    data width; must be a multiple of BYTE_SIZE
//  BYTE_SIZE   8     bits per byte-enable lane; NBYTES = WIDTH/BYTE_SIZE
//  ADDR_W      11    address width; DEPTH = 2**ADDR_W words
//  OUTDATA_REG 0     1 = extra output register on both q ports (read latency 2)
//  RDW_NEW     0     mixed-port same-address read-during-write: 1 = B sees new data, 0 = old
//  INIT_VALUE  0     word written to every location by the clear sequencer
// PORTS
//  clock       in   1        single clock, all logic on posedge
//  rst         in   1        synchronous, active-high reset
//  clocken     in   1        port enable; 0 freezes port A/B operations and q registers
//  busy        out  1        1 while reset or clear sweep active; ports ignored
//  a_wren      in   1        port A write strobe
//  a_byteena   in   NBYTES   port A byte lanes to write (bit i -> bits [i*BYTE_SIZE +: BYTE_SIZE])
//  a_addr      in   ADDR_W   port A address
//  a_data      in   WIDTH    port A write data
//  a_q         out  WIDTH    port A read data
//  b_addr      in   ADDR_W   port B read address
//  b_q         out  WIDTH    port B read data
// BEHAVIOUR
//  Reset: rst=1 -> FSM=CLEAR, sweep ptr=0, busy=1, a_q=b_q=0 (incl. OUTDATA_REG stage).
//  FSM CLEAR: each cycle after rst falls writes INIT_VALUE (all lanes) to ptr, ptr+1;
//   clocken ignored; at ptr=DEPTH-1 write last word, -> READY next cycle; busy=0 in READY.
//   Sweep takes exactly DEPTH cycles. rst mid-sweep restarts at ptr=0. rst in READY -> CLEAR.
//  FSM READY, clocken=1: a_wren=1 writes lanes with a_byteena=1 at a_addr; other lanes keep.
//   a_wren=1 with a_byteena=0 is a no-op write. Write committed at this posedge (not delayed).
//  Reads: address sampled at posedge N; q valid after posedge N (OUTDATA_REG=0) or N+1 (=1).
//   q holds its value while clocken=0 or no new address sampled; q never X after reset.
//  Port A read-during-write (same port): a_q returns OLD word at a_addr.
//  Mixed port, a_wren=1 and b_addr==a_addr same cycle: RDW_NEW=1 -> b_q = merged new word
//   (byte-masked); RDW_NEW=0 -> b_q = old word. Different addresses: no interaction.
//  clocken=0 in READY: no write, address regs and q regs hold, memory unchanged.
//  During CLEAR: a_wren ignored (dropped, not queued); a_q/b_q held at 0.
//  Address wrap: none; addresses index directly, full ADDR_W range valid.
//  Elaboration error ($error/$finish) if WIDTH % BYTE_SIZE != 0.
// STRUCTURE
//  Shared include sync_ram_defs.vh: FSM state encodings (CLEAR=1'b0, READY=1'b1) and
//   NBYTES/mask helper macro; reused by cache and regfile wrappers.
//  Sub-module sync_ram_byte_merge: combinational (old, new, byteena) -> merged word;
//   used for both the memory write and the RDW_NEW bypass so they cannot diverge.
//  Top holds memory array, clear FSM/pointer, address/data regs, optional output regs.
// TESTING
//  1 Clear: ADDR_W=4, INIT_VALUE=32'hDEADBEEF, rst 3 cycles -> busy=1 for exactly 16 cycles
//    after rst falls; then reading all 16 addresses on A and B returns 32'hDEADBEEF.
//  2 Byte merge: write 32'h11223344 @5 (byteena 4'hF), then 32'hAABBCCDD @5 byteena 4'b0101
//    -> read @5 = 32'h11BB33DD on both ports; byteena 4'h0 write leaves it unchanged.
//  3 RDW: @7 holds 32'h0; same cycle a_wren @7 data 32'h12345678, b_addr=7 -> b_q=32'h12345678
//    with RDW_NEW=1, 32'h0 with RDW_NEW=0; a_q=32'h0 in both builds.
//  4 Latency: OUTDATA_REG=1, addr 5 presented at posedge N -> b_q updates after posedge N+1
//    only; OUTDATA_REG=0 -> after posedge N.
//  5 clocken: clocken=0 with a_wren=1 @3 data 32'hFFFFFFFF and new addresses -> memory @3
//    unchanged, a_q/b_q hold previous values; clocken=1 resumes with 1-cycle latency.
//  6 Reset mid-sweep: ADDR_W=4, assert rst at sweep ptr=9, release -> busy high another full
//    16 cycles; writes issued during busy are lost; final contents all INIT_VALUE.

Source files
------------

// File: rtl/sync_ram_dp_pkg.sv
// Shared types and helpers for the simple-dual-port RAM and its wrappers.
package sync_ram_dp_pkg;

  // Clear sequencer states; encodings are shared with the cache/regfile wrappers.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  function automatic int nbytes_of(input int width, input int byte_size);
    return width / byte_size;
  endfunction

endpackage

// File: rtl/sync_ram_dp_byte_merge.sv
// Byte-lane merge of a new word over an old word. One instance feeds both the
// memory write and the mixed-port bypass, so the two paths always agree.
module sync_ram_dp_byte_merge
  import sync_ram_dp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BYTE_SIZE = 8
) (
  input  logic [WIDTH-1:0]           old_i,
  input  logic [WIDTH-1:0]           new_i,
  input  logic [WIDTH/BYTE_SIZE-1:0] byteena_i,
  output logic [WIDTH-1:0]           merged_o
);

  localparam int NBYTES = nbytes_of(WIDTH, BYTE_SIZE);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < NBYTES; i++) begin
      if (byteena_i[i]) begin
        merged_o[i*BYTE_SIZE +: BYTE_SIZE] = new_i[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

endmodule

// File: rtl/sync_ram_dp.sv
// Simple-dual-port synchronous RAM: port A read/write with byte enables, port B
// read-only, optional output register, and a post-reset clear sweep.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_CLEAR | sweep writes INIT_VALUE to ptr each cycle; ports ignored, busy=1
//   ST_READY | normal operation gated by clocken; busy=0
module sync_ram_dp
  import sync_ram_dp_pkg::*;
#(
  parameter int             WIDTH       = 32,
  parameter int             BYTE_SIZE   = 8,
  parameter int             ADDR_W      = 11,
  parameter int             OUTDATA_REG = 0,
  parameter int             RDW_NEW     = 0,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       clocken,
  output logic                       busy,
  input  logic                       a_wren,
  input  logic [WIDTH/BYTE_SIZE-1:0] a_byteena,
  input  logic [ADDR_W-1:0]          a_addr,
  input  logic [WIDTH-1:0]           a_data,
  output logic [WIDTH-1:0]           a_q,
  input  logic [ADDR_W-1:0]          b_addr,
  output logic [WIDTH-1:0]           b_q
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  if (WIDTH % BYTE_SIZE != 0) begin : g_bad_width
    $error("sync_ram_dp: WIDTH must be a multiple of BYTE_SIZE");
  end

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  logic              port_en;
  logic [WIDTH-1:0]  a_old;
  logic [WIDTH-1:0]  b_old;
  logic [WIDTH-1:0]  a_merged;
  logic [WIDTH-1:0]  a_rd_q, a_rd_d;
  logic [WIDTH-1:0]  b_rd_q, b_rd_d;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (ptr_q == PTR_LAST) begin
        state_d = ST_READY;
      end
    end
  end

  assign busy    = (state_q == ST_CLEAR);
  assign port_en = (state_q == ST_READY) && clocken;

  assign a_old = mem_q[a_addr];
  assign b_old = mem_q[b_addr];

  sync_ram_dp_byte_merge #(
    .WIDTH     (WIDTH),
    .BYTE_SIZE (BYTE_SIZE)
  ) u_merge (
    .old_i     (a_old),
    .new_i     (a_data),
    .byteena_i (a_byteena),
    .merged_o  (a_merged)
  );

  // Sweep and port A share the single write port; the sweep owns it while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = a_addr;
    mem_wdata = a_merged;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = INIT_VALUE;
      end else if (port_en && a_wren) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    a_rd_d = a_old;
    b_rd_d = b_old;
    if ((RDW_NEW != 0) && a_wren && (a_addr == b_addr)) begin
      b_rd_d = a_merged;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      a_rd_q <= '0;
      b_rd_q <= '0;
    end else if (port_en) begin
      a_rd_q <= a_rd_d;
      b_rd_q <= b_rd_d;
    end
  end

  if (OUTDATA_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] a_out_q;
    logic [WIDTH-1:0] b_out_q;

    always_ff @(posedge clock) begin
      if (rst) begin
        a_out_q <= '0;
        b_out_q <= '0;
      end else if (port_en) begin
        a_out_q <= a_rd_q;
        b_out_q <= b_rd_q;
      end
    end

    assign a_q = a_out_q;
    assign b_q = b_out_q;
  end else begin : g_no_out_reg
    assign a_q = a_rd_q;
    assign b_q = b_rd_q;
  end

endmodule
